// File: rtl/morse_rx_deserializer_pkg.sv
// morse_rx_deserializer_pkg: Morse timing constants and receiver state encoding shared by both ends of the link
// Thresholds are multiples of the time unit U (clock cycles per unit):
//   dash if mark >= MULT_RAYA*U, letter gap at MULT_LETRA*U, word gap at MULT_PALABRA*U,
//   mark counter saturates at MULT_SAT*U.
package morse_rx_deserializer_pkg;

   localparam int MULT_RAYA    = 2;
   localparam int MULT_LETRA   = 3;
   localparam int MULT_PALABRA = 7;
   localparam int MULT_SAT     = 4;

   localparam int MAX_ELEM = 5;

   localparam logic ELEM_PUNTO = 1'b0;
   localparam logic ELEM_RAYA  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      MARCA,
      ESPACIO,
      ESPERA_PALABRA
   } estado_t;

endpackage

// File: rtl/morse_rx_deserializer_sincronizador.sv
// sincronizador: two-flop synchronizer for the asynchronous keyed line
// Ports: clk clock, rst_n sync active-low reset, d_i async input, q_o synchronized output
module sincronizador (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk) ff_q <= !rst_n ? 2'b00 : {ff_q[0], d_i};

   assign q_o = ff_q[1];

endmodule

// File: rtl/morse_rx_deserializer.sv
// morse_rx_deserializer: decodes a keyed Morse line into packed dot/dash symbols
// Ports: clk clock; rst_n sync active-low reset; entrada_morse async line (1 = mark);
//        simbolo elements (bit k = element k, 1 = dash); longitud element count 1..5;
//        valido new-symbol pulse; espacio_palabra word-gap pulse; error overflow-discard pulse
module morse_rx_deserializer
   import morse_rx_deserializer_pkg::*;
#(
   parameter int CLKS_PER_UNIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entrada_morse,
   output logic [4:0] simbolo,
   output logic [2:0] longitud,
   output logic       valido,
   output logic       espacio_palabra,
   output logic       error
);

   localparam int CW = $clog2(MULT_PALABRA * CLKS_PER_UNIT + 1);

   localparam logic [CW-1:0] UNO       = CW'(1);
   localparam logic [CW-1:0] T_RAYA    = CW'(MULT_RAYA * CLKS_PER_UNIT);
   localparam logic [CW-1:0] T_LETRA   = CW'(MULT_LETRA * CLKS_PER_UNIT);
   localparam logic [CW-1:0] T_PALABRA = CW'(MULT_PALABRA * CLKS_PER_UNIT);
   localparam logic [CW-1:0] T_SAT     = CW'(MULT_SAT * CLKS_PER_UNIT);
   localparam logic [2:0]    LEN_MAX   = 3'(MAX_ELEM);

   logic          s;
   logic          elem;
   estado_t       estado_q;
   logic [CW-1:0] on_cnt_q;
   logic [CW-1:0] off_cnt_q;
   logic [2:0]    len_q;
   logic          ovf_q;
   logic [4:0]    work_q;
   logic [4:0]    simbolo_q;
   logic [2:0]    longitud_q;
   logic          valido_q;
   logic          espacio_q;
   logic          error_q;

   sincronizador u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (entrada_morse),
      .q_o  (s)
   );

   assign elem = (on_cnt_q >= T_RAYA) ? ELEM_RAYA : ELEM_PUNTO;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q   <= IDLE;
         on_cnt_q   <= '0;
         off_cnt_q  <= '0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         work_q     <= '0;
         simbolo_q  <= '0;
         longitud_q <= '0;
         valido_q   <= 1'b0;
         espacio_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         valido_q  <= 1'b0;
         espacio_q <= 1'b0;
         error_q   <= 1'b0;
         case (estado_q)
            IDLE, ESPERA_PALABRA: begin
               if (s) begin
                  estado_q <= MARCA;
                  on_cnt_q <= UNO;
                  len_q    <= '0;
                  work_q   <= '0;
                  ovf_q    <= 1'b0;
               end else if (estado_q == ESPERA_PALABRA) begin
                  if (off_cnt_q == T_PALABRA) begin
                     espacio_q <= 1'b1;
                     estado_q  <= IDLE;
                  end else begin
                     off_cnt_q <= off_cnt_q + UNO;
                  end
               end
            end
            MARCA: begin
               if (s) begin
                  if (on_cnt_q != T_SAT) on_cnt_q <= on_cnt_q + UNO;
               end else begin
                  if (len_q < LEN_MAX) begin
                     work_q <= work_q | (5'(elem) << len_q);
                     len_q  <= len_q + 3'd1;
                  end else begin
                     ovf_q <= 1'b1;
                  end
                  off_cnt_q <= UNO;
                  estado_q  <= ESPACIO;
               end
            end
            ESPACIO: begin
               // The letter-gap check wins over a new mark in the same cycle so
               // that a low of exactly 3*U closes the symbol.
               if (off_cnt_q == T_LETRA) begin
                  if (ovf_q) begin
                     error_q <= 1'b1;
                     ovf_q   <= 1'b0;
                  end else begin
                     valido_q   <= 1'b1;
                     simbolo_q  <= work_q;
                     longitud_q <= len_q;
                  end
                  off_cnt_q <= off_cnt_q + UNO;
                  estado_q  <= ESPERA_PALABRA;
               end else if (s) begin
                  estado_q <= MARCA;
                  on_cnt_q <= UNO;
               end else begin
                  off_cnt_q <= off_cnt_q + UNO;
               end
            end
            default: estado_q <= IDLE;
         endcase
      end
   end

   assign simbolo         = simbolo_q;
   assign longitud        = longitud_q;
   assign valido          = valido_q;
   assign espacio_palabra = espacio_q;
   assign error           = error_q;

endmodule

// File: tb/tb_morse_rx_deserializer.sv
// tb_morse_rx_deserializer: directed scoreboard bench for the Morse receiver with U=4
module tb_morse_rx_deserializer;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       entrada_morse = 1'b0;
   logic [4:0] simbolo;
   logic [2:0] longitud;
   logic       valido;
   logic       espacio_palabra;
   logic       error;

   typedef struct {
      logic [1:0] k;
      logic [4:0] s;
      logic [2:0] l;
      int         t;
   } exp_t;

   exp_t       q[$];
   int         nvec = 0;
   int         nerr = 0;
   int         cyc = 0;
   int         last_ve = 0;
   logic [4:0] m_s = '0;
   logic [2:0] m_l = '0;
   logic       prev_p = 1'b0;

   morse_rx_deserializer #(.CLKS_PER_UNIT(U)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .entrada_morse  (entrada_morse),
      .simbolo        (simbolo),
      .longitud       (longitud),
      .valido         (valido),
      .espacio_palabra(espacio_palabra),
      .error          (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      nvec++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic mk(input int h);
      entrada_morse = 1'b1;
      repeat (h) @(negedge clk);
   endtask

   task automatic gap(input int l);
      entrada_morse = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   // valido is due 3*U+2 edges after the first edge sampling the line low,
   // which is the edge after this negedge.
   task automatic pv(input logic [4:0] s, input logic [2:0] l);
      q.push_back('{2'd0, s, l, cyc + 3 * U + 3});
      m_s = s;
      m_l = l;
   endtask

   task automatic pe();
      q.push_back('{2'd1, m_s, m_l, 0});
   endtask

   task automatic pw();
      q.push_back('{2'd2, m_s, m_l, 0});
   endtask

   always @(negedge clk) begin
      logic [2:0] p;
      exp_t       e;
      p = {espacio_palabra, error, valido};
      if (p != 3'b000) begin
         chk("onehot", 32'($onehot(p)), 1);
         chk("no_back_to_back", 32'(prev_p), 0);
         if (q.size() == 0) begin
            chk("unexpected_pulse", 32'(p), 0);
         end else begin
            e = q.pop_front();
            chk("kind", 32'(p), 32'(3'b001 << e.k));
            chk("simbolo", 32'(simbolo), 32'(e.s));
            chk("longitud", 32'(longitud), 32'(e.l));
            if (e.t != 0) chk("valido_delay", cyc, e.t);
            if (e.k == 2'd2) chk("word_gap_delay", cyc - last_ve, 4 * U);
         end
         if (valido || error) last_ve = cyc;
      end
      prev_p = |p;
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_simbolo", 32'(simbolo), 0);
      chk("rst_longitud", 32'(longitud), 0);
      chk("rst_valido", 32'(valido), 0);
      chk("rst_espacio", 32'(espacio_palabra), 0);
      chk("rst_error", 32'(error), 0);
      rst_n = 1'b1;
      gap(20);

      mk(4); gap(4); mk(12); pv(5'b00010, 3'd2); pw(); gap(40);

      mk(7); pv(5'b00000, 3'd1); pw(); gap(40);
      mk(8); pv(5'b00001, 3'd1); pw(); gap(40);

      for (int i = 0; i < 6; i++) begin
         mk(4);
         if (i < 5) gap(4);
      end
      pe(); pw(); gap(40);
      chk("ovf_simbolo_held", 32'(simbolo), 32'(5'b00001));
      chk("ovf_longitud_held", 32'(longitud), 1);

      mk(4); pv(5'b00000, 3'd1); gap(12);
      mk(12); pv(5'b00001, 3'd1); pw(); gap(40);

      for (int i = 0; i < 5; i++) begin
         mk(12);
         if (i < 4) gap(11);
      end
      pv(5'b11111, 3'd5); pw(); gap(40);

      mk(11);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_simbolo", 32'(simbolo), 0);
      chk("midrst_longitud", 32'(longitud), 0);
      chk("midrst_pulses", 32'({valido, error, espacio_palabra}), 0);
      rst_n = 1'b1;
      m_s = '0;
      m_l = '0;
      gap(40);
      chk("post_rst_simbolo", 32'(simbolo), 0);

      mk(4); pv(5'b00000, 3'd1); pw(); gap(40);

      chk("pending_expected", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/morse_rx_deserializer.md
MORSE_RX_DESERIALIZER -- requirements
Module: morse_rx_deserializer

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_UNIT, default 4, giving the clock cycles per Morse time unit (U); legal range 2..64.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have the port entrada_morse, input, 1 bit: asynchronous keyed Morse line, high = mark.
REQ-005 The block SHALL have the port simbolo, output, 5 bits: received elements; bit k = element k, with k=0 the first element received; 0 = dot, 1 = dash.
REQ-006 The block SHALL have the port longitud, output, 3 bits: number of valid elements in simbolo, 1..5.
REQ-007 The block SHALL have the port valido, output, 1 bit: one-cycle pulse marking simbolo/longitud as new.
REQ-008 The block SHALL have the port espacio_palabra, output, 1 bit: one-cycle pulse on an inter-word gap.
REQ-009 The block SHALL have the port error, output, 1 bit: one-cycle pulse when a symbol with more than 5 elements is discarded.

Function
REQ-010 entrada_morse SHALL pass through a 2-flop synchronizer; s denotes the synchronizer output, and all timing below counts from s.
REQ-011 The FSM SHALL have the states IDLE, MARCA, ESPACIO and ESPERA_PALABRA.
REQ-012 IDLE: s rising -> MARCA, on_cnt=1, element count len=0, simbolo working register cleared.
REQ-013 MARCA: each cycle s=1, on_cnt SHALL increment, saturating at 4*U.
REQ-014 MARCA, s falling: the element SHALL be classified as a dot if on_cnt < 2*U, else as a dash.
REQ-015 On that same falling edge, if len<5, the element bit SHALL be written at index len and len incremented; if len==5, the overflow flag SHALL be set.
REQ-016 On that same falling edge, off_cnt SHALL be set to 1 and the FSM SHALL go to ESPACIO.
REQ-017 ESPACIO: s=1 -> MARCA (inter-element gap, on_cnt=1, len retained).
REQ-018 ESPACIO: s=0 -> off_cnt increments.
REQ-019 ESPACIO: at off_cnt==3*U, if overflow is clear, the block SHALL pulse valido and load simbolo/longitud.
REQ-020 ESPACIO: at off_cnt==3*U, if overflow is set, the block SHALL pulse error, leave simbolo/longitud unchanged and clear overflow.
REQ-021 ESPACIO: at off_cnt==3*U, the FSM SHALL go to ESPERA_PALABRA in either case.
REQ-022 ESPERA_PALABRA: s rising -> MARCA with a new symbol (len=0, working register cleared, on_cnt=1).
REQ-023 ESPERA_PALABRA: off_cnt==7*U -> espacio_palabra pulse, then IDLE; off_cnt SHALL saturate there, and only one pulse is allowed per gap.
REQ-024 Unused simbolo bits (index >= longitud) SHALL be 0.
REQ-025 simbolo/longitud SHALL hold their last loaded value until the next valido.
REQ-026 valido, error and espacio_palabra SHALL be mutually exclusive in any cycle and SHALL never be high for two consecutive cycles.
REQ-027 Timing: valido SHALL assert exactly 3*U+2 cycles after the first rising edge of clk that samples entrada_morse low after the last mark.
REQ-028 Timing: espacio_palabra SHALL assert 4*U cycles after valido/error when the line stays low.
REQ-029 A mark in progress SHALL never produce valido; in IDLE, a low line SHALL produce no output pulses.
REQ-030 Counter widths SHALL hold 7*U without wrap for the maximum U.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL clear the synchronizer flops, state (to IDLE), on_cnt, off_cnt, len, overflow, simbolo, longitud, valido, espacio_palabra and error to 0.
REQ-032 Reset asserted mid-symbol SHALL discard the partial symbol with no valido or error.
REQ-033 After release, a line already high SHALL be treated as a new mark 2 cycles later.

Structure
REQ-034 The state encodings and the threshold multipliers (2, 3, 7, 4) SHALL live in the shared Morse defines include, next to the transmitter constants, so both ends agree on the dot/dash/gap definitions.
REQ-035 The 2-flop synchronizer SHALL be the sub-module sincronizador; the FSM, counters and shift/pack logic SHALL stay in this module.
REQ-036 The bit ordering (element 0 in bit 0) SHALL match the transmitter's 5-element select order, so symbols round-trip unchanged.

Verification (U=4)
REQ-037 Letter A: 4 high, 4 low, 12 high, then low -> valido once with simbolo=00010, longitud=2; then espacio_palabra 16 cycles later.
REQ-038 Threshold: a single 7-cycle mark -> simbolo=00000, longitud=1; a single 8-cycle mark -> simbolo=00001, longitud=1.
REQ-039 Overflow: 6 dots separated by 4-cycle gaps -> no valido, one error pulse; previous simbolo/longitud unchanged.
REQ-040 Back-to-back: E then T with a 12-cycle gap (no word gap) -> valido 00000/1, then valido 00001/1, with no espacio_palabra between them.
REQ-041 Reset mid-dash: pull rst_n low for 1 cycle during a 12-cycle mark -> all outputs 0, no pulses; the next clean dot decodes as 00000/1.
REQ-042 Gap boundary: an 11-cycle low inside a symbol keeps the symbol open; a 12-cycle low closes it; 5 dashes -> simbolo=11111, longitud=5.
